req_grant_arbiter: RTL and testbench

- Responder side of the request/grant handshake: collects `request` lines from N_REQ requesters and returns one-hot `grant`.
- Round-robin fairness, a bounded grant tenure, and a guaranteed idle gap between tenures.
- Guarantees the invariant `grant[i] -> request[i]` in every cycle, which is what requester-side checkers assert against.
- Sits between requesting agents and a shared resource.

---
 rtl/req_grant_arbiter.sv | 162 ++++++++++++++++
 tb/tb_req_grant_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/req_grant_arbiter.sv
// req_grant_arbiter: round-robin request/grant responder with bounded tenure
// and a fixed idle gap between tenures. grant is always masked by request,
// so grant[i] implies request[i] in every cycle.
// Optional checks: define REQ_GRANT_ARBITER_ASSERT_EN to compile the
// CHK_GNT_ONEHOT / CHK_GNT_HAS_REQ / CHK_HOLD_BOUND immediate assertions.
module req_grant_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  request,
    output logic [N_REQ-1:0]                  grant,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
    output logic                              busy,
    output logic [$clog2(MAX_HOLD+1)-1:0]     hold_cnt,
    output logic                              timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(GAP + 1);
    // The tenure counter doubles as the gap counter, so it must fit both.
    localparam int CW = (HW > GW) ? HW : GW;

    localparam logic [CW-1:0]    MAX_C    = CW'(MAX_HOLD);
    localparam logic [CW-1:0]    GAP_LAST = CW'(GAP - 1);
    localparam logic [IW-1:0]    LAST_ID  = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAPW
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [IW-1:0]    win;
    logic [IW-1:0]    ptr_after_owner;
    int unsigned      idx;

    // Round-robin search: first set request bit from ptr upward, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && request[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign ptr_after_owner = (id_q == LAST_ID) ? '0 : id_q + IW'(1);

    // Next-state and datapath updates for the IDLE/GRANT/GAPW sequence.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    grant_d = ONE_HOT0 << win;
                    id_d    = win;
                    cnt_d   = CW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A request drop wins over a simultaneous tenure expiry.
                if (!request[id_q] || cnt_q >= MAX_C) begin
                    timeout_d = request[id_q];
                    grant_d   = '0;
                    ptr_d     = ptr_after_owner;
                    cnt_d     = '0;
                    state_d   = GAPW;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAPW: begin
                grant_d = '0;
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant    = grant_q & request;
    assign grant_id = id_q;
    assign busy     = (state_q == GRANT);
    assign hold_cnt = cnt_q[HW-1:0];
    assign timeout  = timeout_q;

`ifdef REQ_GRANT_ARBITER_ASSERT_EN
    logic info_done;

    // Protocol checks; the informational pass message fires once per tenure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            info_done <= 1'b0;
        end else begin
            CHK_GNT_ONEHOT: assert ($onehot0(grant))
                else $error("CHK_GNT_ONEHOT t=%0t grant=%b request=%b", $time, grant, request);
            CHK_GNT_HAS_REQ: assert ((grant & ~request) == '0) begin
                if (busy && !info_done) begin
                    $info("CHK_GNT_HAS_REQ holds for tenure of id %0d", grant_id);
                    info_done <= 1'b1;
                end
            end else $error("CHK_GNT_HAS_REQ t=%0t grant=%b request=%b", $time, grant, request);
            CHK_HOLD_BOUND: assert (32'(hold_cnt) <= MAX_HOLD)
                else $error("CHK_HOLD_BOUND t=%0t grant=%b request=%b", $time, grant, request);
            if (!busy) info_done <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Testbench for req_grant_arbiter: directed scenarios plus randomized
// request traffic, all checked against a cycle-level reference model.
module tb_req_grant_arbiter;

    localparam int N   = 4;
    localparam int MH  = 8;
    localparam int GP  = 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         busy;
    logic [3:0]   hold_cnt;
    logic         timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the resource, how long, what is left of the gap.
    int m_owner;     // -1 when nobody holds the resource
    int m_id;
    int m_cnt;
    int m_gap_left;
    int m_ptr;
    int m_tout;

    req_grant_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .GAP(GP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .request  (request),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .hold_cnt (hold_cnt),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner    = -1;
        m_id       = 0;
        m_cnt      = 0;
        m_gap_left = 0;
        m_ptr      = 0;
        m_tout     = 0;
    endfunction

    // One clock of the arbitration rules, given the sampled request vector.
    function automatic void model_step(input logic [N-1:0] r);
        m_tout = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_cnt == MH) begin
                m_tout     = r[m_owner] ? 1 : 0;
                m_owner    = -1;
                m_ptr      = (m_id + 1) % N;
                m_gap_left = GP;
                m_cnt      = 0;
            end else begin
                m_cnt++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            m_cnt = (m_gap_left == 0) ? 0 : m_cnt + 1;
        end else begin
            m_cnt = 0;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_id  = m_owner;
                m_cnt = 1;
            end
        end
    endfunction

    function automatic int unsigned model_grant(input logic [N-1:0] r);
        if (m_owner >= 0 && r[m_owner]) return 32'd1 << m_owner;
        return 0;
    endfunction

    task automatic check_all();
        check("grant",    grant,    model_grant(request));
        check("grant_id", grant_id, m_id);
        check("busy",     busy,     (m_owner >= 0) ? 1 : 0);
        check("hold_cnt", hold_cnt, m_cnt);
        check("timeout",  timeout,  m_tout);
    endtask

    // Called at a falling edge: drive, check, clock, return at the next falling edge.
    task automatic cycle(input logic [N-1:0] r);
        request = r;
        #1;
        check_all();
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_grant", grant, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [N-1:0] r;
    int           to_cnt;

    initial begin
        rst_n   = 1'b0;
        request = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single requester held three cycles, then released.
        cycle(4'b0001);
        repeat (3) cycle(4'b0001);
        repeat (4) cycle(4'b0000);

        // Everybody requesting: rotating 8-cycle tenures with timeouts.
        to_cnt = 0;
        repeat (48) begin
            cycle(4'b1111);
            if (timeout) to_cnt++;
        end
        check("timeouts_1111", to_cnt, 4);
        repeat (3) cycle(4'b0000);

        // Requester 0 constant while requester 2 toggles.
        for (int i = 0; i < 60; i++) cycle((i % 6 < 3) ? 4'b0101 : 4'b0001);
        repeat (3) cycle(4'b0000);

        // Reset in the middle of a tenure at hold_cnt=5.
        for (int i = 0; i < 20 && !(m_owner >= 0 && m_cnt == 5); i++) cycle(4'b0001);
        check("pre_rst_hold", hold_cnt, 5);
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        cycle(4'b1010);
        cycle(4'b1010);
        check("rst_ptr0_win", grant_id, 1);
        repeat (4) cycle(4'b0000);

        // Request drops exactly as hold_cnt reaches MAX_HOLD.
        do_reset();
        repeat (MH) cycle(4'b0001);
        check("max_hold_seen", hold_cnt, MH);
        cycle(4'b0000);
        check("drop_at_max_tout", timeout, 0);
        repeat (2) cycle(4'b0000);
        cycle(4'b1111);
        check("drop_at_max_ptr", grant_id, 1);
        repeat (3) cycle(4'b0000);

        // Randomized sticky request traffic.
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) r = N'($urandom);
            cycle(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
